// File: rtl/execute_mc.sv
// -----------------------------------------------------------------------------
// execute_mc -- Y86-64 execute stage with a multi-cycle shift-add multiplier.
//
// Purpose:
//   Accepts one decoded instruction per issue handshake, runs the ALU and
//   condition logic, and presents a registered result behind a valid/ready
//   handshake. Single-cycle operations present on the edge after acceptance.
//   mulq (when built in) runs one multiplier bit per cycle and presents
//   DATA_W+1 cycles after acceptance.
//
// Configuration macro:
//   EXECUTE_MC_MULQ_EN -- when defined, builds in the MUL state and mulq
//                         (OPq ifun 4). When undefined, mulq decodes as an
//                         invalid instruction (stat INS).
//
// Ports:
//   clk_i, rst_n_i             clock, synchronous active-low reset
//   in_valid_i / in_ready_o    issue handshake
//   icode_i, ifun_i            instruction code / function
//   valA_i, valB_i, valC_i     operands
//   dstE_i                     requested destination register
//   m_stat_i, W_stat_i         downstream status (gates CC update)
//   flush_i                    kills in-flight and presented work
//   out_valid_o / out_ready_i  result handshake
//   valE_o, dstE_o, cnd_o,
//   icode_o, stat_o            registered result fields
//   cc_o                       architectural condition codes {ZF,SF,OF}
// -----------------------------------------------------------------------------
module execute_mc #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [DATA_W-1:0] valA_i,
    input  logic [DATA_W-1:0] valB_i,
    input  logic [DATA_W-1:0] valC_i,
    input  logic [REG_W-1:0]  dstE_i,
    input  logic [2:0]        m_stat_i,
    input  logic [2:0]        W_stat_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] valE_o,
    output logic [REG_W-1:0]  dstE_o,
    output logic              cnd_o,
    output logic [3:0]        icode_o,
    output logic [2:0]        stat_o,
    output logic [2:0]        cc_o
);

    localparam logic [REG_W-1:0]  RNONE = '1;
    localparam logic [DATA_W-1:0] POS8  = DATA_W'(8);
    localparam logic [DATA_W-1:0] NEG8  = DATA_W'(-8);

    localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2,
                           I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5,
                           I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                           I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_XOR = 4'd3;

    localparam logic [2:0] S_BUB = 3'd0, S_AOK = 3'd1, S_INS = 3'd3;

`ifdef EXECUTE_MC_MULQ_EN
    localparam logic [3:0] F_MUL  = 4'd4;
    localparam logic [3:0] F_LAST = 4'd4;
    localparam int         CNT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_mul;
`else
    localparam logic [3:0] F_LAST = 4'd3;
`endif

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   val_e_q, val_e_d;
    logic [REG_W-1:0]    dst_e_q, dst_e_d;
    logic                cnd_q, cnd_d;
    logic [3:0]          icode_q, icode_d;
    logic [2:0]          stat_q, stat_d;
    logic [2:0]          cc_q, cc_d;

    logic                accept, instr_ok, is_opq, down_ok, cond_true, cnd_new;
    logic                sf_xor_of, alu_of;
    logic [3:0]          alu_fun;
    logic [DATA_W-1:0]   alu_a, alu_b, alu_res;
    logic [REG_W-1:0]    dst_new;

`ifdef EXECUTE_MC_MULQ_EN
    assign in_ready_o = (state_q == IDLE) && (!out_valid_q || out_ready_i) && !flush_i;
    assign is_mul     = (icode_i == I_OPQ) && (ifun_i == F_MUL);
`else
    assign in_ready_o = (!out_valid_q || out_ready_i) && !flush_i;
`endif

    assign accept  = in_valid_i && in_ready_o;
    assign is_opq  = (icode_i == I_OPQ);
    // A faulting instruction further down the pipe must not see flags from
    // younger work.
    assign down_ok = !(m_stat_i inside {3'd2, 3'd3, 3'd4}) &&
                     !(W_stat_i inside {3'd2, 3'd3, 3'd4});

    // Branch/move condition from the flags currently held (i.e. at acceptance).
    always_comb begin
        sf_xor_of = cc_q[1] ^ cc_q[0];
        case (ifun_i)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = sf_xor_of || cc_q[2];
            4'd2:    cond_true = sf_xor_of;
            4'd3:    cond_true = cc_q[2];
            4'd4:    cond_true = !cc_q[2];
            4'd5:    cond_true = !sf_xor_of;
            4'd6:    cond_true = !sf_xor_of && !cc_q[2];
            default: cond_true = 1'b0;
        endcase
        cnd_new = ((icode_i == I_RRMOVQ) || (icode_i == I_JXX)) ? cond_true : 1'b1;
        dst_new = ((icode_i == I_RRMOVQ) && !cond_true) ? RNONE : dstE_i;
    end

    // Operand selection and instruction validity.
    always_comb begin
        instr_ok = 1'b1;
        alu_a    = '0;
        alu_b    = '0;
        alu_fun  = F_ADD;
        case (icode_i)
            I_HALT, I_NOP: ;
            I_RRMOVQ: begin
                alu_a    = valA_i;
                instr_ok = (ifun_i <= 4'd6);
            end
            I_IRMOVQ: alu_a = valC_i;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC_i;
                alu_b = valB_i;
            end
            I_OPQ: begin
                alu_a    = valA_i;
                alu_b    = valB_i;
                alu_fun  = ifun_i;
                instr_ok = (ifun_i <= F_LAST);
            end
            I_JXX: instr_ok = (ifun_i <= 4'd6);
            I_CALL, I_PUSHQ: begin
                alu_a = NEG8;
                alu_b = valB_i;
            end
            I_RET, I_POPQ: begin
                alu_a = POS8;
                alu_b = valB_i;
            end
            default: instr_ok = 1'b0;
        endcase
    end

    // Single-cycle ALU; invalid instructions produce zero.
    always_comb begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
        case (alu_fun)
            F_SUB: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != alu_b[DATA_W-1]);
            end
            F_AND: begin
                alu_res = alu_b & alu_a;
                alu_of  = 1'b0;
            end
            F_XOR: begin
                alu_res = alu_b ^ alu_a;
                alu_of  = 1'b0;
            end
            default: ;
        endcase
        if (!instr_ok) begin
            alu_res = '0;
        end
    end

    // Next-state logic: output handshake, result capture, CC update and the
    // multiplier sequence. Flush overrides everything at the end.
    always_comb begin
        out_valid_d = out_valid_q;
        val_e_d     = val_e_q;
        dst_e_d     = dst_e_q;
        cnd_d       = cnd_q;
        icode_d     = icode_q;
        stat_d      = stat_q;
        cc_d        = cc_q;
`ifdef EXECUTE_MC_MULQ_EN
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
`endif
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            dst_e_d = dst_new;
            cnd_d   = cnd_new;
            icode_d = icode_i;
            stat_d  = instr_ok ? S_AOK : S_INS;
`ifdef EXECUTE_MC_MULQ_EN
            if (is_mul) begin
                // The product accumulates directly in the result register.
                state_d  = MUL;
                val_e_d  = '0;
                mcand_d  = valB_i;
                mplier_d = valA_i;
                cnt_d    = '0;
            end else begin
`endif
                out_valid_d = 1'b1;
                val_e_d     = alu_res;
                if (is_opq && instr_ok && down_ok) begin
                    cc_d = {alu_res == '0, alu_res[DATA_W-1], alu_of};
                end
`ifdef EXECUTE_MC_MULQ_EN
            end
`endif
        end
`ifdef EXECUTE_MC_MULQ_EN
        case (state_q)
            MUL: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    if (down_ok) begin
                        cc_d = {val_e_q == '0, val_e_q[DATA_W-1], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) begin
                        val_e_d = val_e_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
`endif
        if (flush_i) begin
`ifdef EXECUTE_MC_MULQ_EN
            state_d = IDLE;
`endif
            out_valid_d = 1'b0;
            cc_d        = cc_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            dst_e_q     <= RNONE;
            cnd_q       <= 1'b0;
            icode_q     <= I_HALT;
            stat_q      <= S_BUB;
            cc_q        <= 3'b100;
`ifdef EXECUTE_MC_MULQ_EN
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            val_e_q     <= val_e_d;
            dst_e_q     <= dst_e_d;
            cnd_q       <= cnd_d;
            icode_q     <= icode_d;
            stat_q      <= stat_d;
            cc_q        <= cc_d;
`ifdef EXECUTE_MC_MULQ_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign valE_o      = val_e_q;
    assign dstE_o      = dst_e_q;
    assign cnd_o       = cnd_q;
    assign icode_o     = icode_q;
    assign stat_o      = stat_q;
    assign cc_o        = cc_q;

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have parameter REG_W, default 4, register-ID width; RNONE is all-ones (4'hF at default).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have ports in_valid_i input 1 and in_ready_o output 1, the issue handshake; transfer occurs when both are high on an edge.
REQ-006 SHALL have ports icode_i and ifun_i, inputs, 4 bits each, the instruction code and function.
REQ-007 SHALL have ports valA_i, valB_i and valC_i, inputs, DATA_W bits each, the operands.
REQ-008 SHALL have port dstE_i, input, REG_W, the requested destination.
REQ-009 SHALL have ports m_stat_i and W_stat_i, inputs, 3 bits each, the downstream stage status (1=AOK, 2=ADR, 3=INS, 4=HLT, 0=BUB).
REQ-010 SHALL have port flush_i, input, 1, kills the in-flight and presented operation.
REQ-011 SHALL have ports out_valid_o output 1 and out_ready_i input 1, the result handshake.
REQ-012 SHALL have registered outputs valE_o (DATA_W), dstE_o (REG_W), cnd_o (1), icode_o (4) and stat_o (3).
REQ-013 SHALL have port cc_o, output, 3, architectural {ZF,SF,OF}.

Function
REQ-014 in_ready_o SHALL equal (state==IDLE) and (!out_valid_o or out_ready_i) and !flush_i.
REQ-015 aluA/aluB SHALL follow Y86 selection: rrmovq/cmovXX valA+0; irmovq valC+0; rmmovq/mrmovq valC+valB; call/pushq valB-8; ret/popq valB+8; OPq per ifun.
REQ-016 OPq ifun SHALL map 0 to B+A, 1 to B-A, 2 to B&A, 3 to B^A and 4 to B*A (the low DATA_W bits).
REQ-017 Single-cycle ops SHALL present their result with out_valid_o=1 on the edge after acceptance (latency 1).
REQ-018 The FSM SHALL have states IDLE, MUL and HOLD. IDLE moves to MUL on an accepted mulq. MUL moves to HOLD after DATA_W shift-add iterations (one bit per cycle, LSB first). HOLD moves to IDLE when the output is taken. Single-cycle ops stay in IDLE.
REQ-019 mulq latency SHALL be DATA_W+1 cycles from acceptance to out_valid_o.
REQ-020 out_valid_o and all result outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-021 cnd_o SHALL be evaluated from cc_o as held at acceptance, for jXX and cmovXX: YES, LE, L, E, NE, GE, G. For all other icodes, cnd_o=1.
REQ-022 dstE_o SHALL be RNONE when icode is rrmovq/cmovXX (2) and the condition is false; otherwise it SHALL be dstE_i.
REQ-023 For an OPq, the flags SHALL be: ZF=(result==0), SF=result[DATA_W-1]. OF for add SHALL be (A,B same sign and result sign differs). OF for sub SHALL be (A,B signs differ and result sign differs from B). OF SHALL be 0 for and/xor/mul.
REQ-024 cc_o SHALL update on the result-presentation edge for an OPq only if neither m_stat_i nor W_stat_i is in {2,3,4} at that edge.
REQ-025 An OPq followed back-to-back by jXX/cmovXX SHALL see the updated CC (acceptance follows presentation).
REQ-026 Unsupported icode/ifun SHALL produce stat_o=3 (INS), valE_o=0 and no CC update; otherwise stat_o=1.
REQ-027 flush_i=1 SHALL force state to IDLE and out_valid_o to 0, abort a mulq in progress, block CC update, and cause any concurrent in_valid_i to be ignored.
REQ-028 Arithmetic SHALL be modulo 2^DATA_W; the constants ±8 SHALL be sign-extended to DATA_W.

Reset
REQ-029 While rst_n_i=0 at an edge: state=IDLE, out_valid_o=0, valE_o=0, dstE_o=RNONE, cnd_o=0, icode_o=0 (HALT), stat_o=0 (BUB), cc_o=3'b100 (ZF set).
REQ-030 Reset mid-mulq SHALL discard the operation, with no output and no CC change.

Configuration
REQ-031 With macro EXECUTE_MC_MULQ_EN defined, the MUL state and mulq (ifun 4) SHALL be built in.
REQ-032 Without EXECUTE_MC_MULQ_EN, mulq SHALL be treated as unsupported per REQ-026, the MUL state SHALL be absent, and in_ready_o SHALL depend only on the output handshake and flush_i.

Verification
REQ-033 With addq A=0x7FFF_FFFF_FFFF_FFFF, B=1 and stat AOK, the bench SHALL check valE_o=0x8000_0000_0000_0000 and cc_o=3'b011 one cycle later.
REQ-034 With subq A=5, B=5, then jne with ifun=4 back-to-back, the bench SHALL check cc_o ZF=1 and cnd_o=0 for the jne.
REQ-035 With cmovl (ifun 2) after subq A=1, B=0 and dstE_i=3, the bench SHALL check cnd_o=1 and dstE_o=3. With cmovge on the same flags, it SHALL check dstE_o=RNONE.
REQ-036 With macro on, mulq A=0x10, B=0x20 and out_ready_i=1, the bench SHALL check out_valid_o rises exactly 65 cycles after acceptance with valE_o=0x200, and in_ready_o=0 throughout.
REQ-037 With a mulq accepted, flush_i pulsed at cycle 10 and then addq 2+3 issued, the bench SHALL check that no mulq result appears and valE_o=5.
REQ-038 With subq producing 0 while W_stat_i=4 (HLT), the bench SHALL check cc_o is unchanged; with out_ready_i=0 for 3 cycles, it SHALL check the outputs are held steady.
